nanomamba_weight_loader: RTL and testbench

Streams packed INT8 weights from the host-side 32-bit AXI-Stream port into the NanoMamba weight SRAM write port. Each accepted word is unpacked into four byte writes at consecutive addresses starting from a programmed base. The loader sits directly upstream of the weight SRAM's write port and drives its write address, data and enable. It is used at initialization, before computation begins reading weights.

---
 rtl/nanomamba_weight_loader.sv | 194 +++++++++++++++++++
 tb/tb_nanomamba_weight_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanomamba_weight_loader.sv
// Unpacks 32-bit AXI-Stream weight words into byte writes on the NanoMamba weight SRAM port.
// Optional feature macro: NANOMAMBA_WLOAD_CHECKSUM_EN builds the running byte checksum; otherwise checksum is 0.
module nanomamba_weight_loader #(
    parameter int DEPTH  = 4736,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int IN_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [IN_W-1:0]   s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [15:0]       checksum
);

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, UNPACK, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [IN_W-1:0]     word_q, word_d;
    logic                last_q, last_d;
    logic [1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                s_tready_q, s_tready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic [ADDR_W:0]     end_addr;
    logic [1:0]          next_idx;
    logic                emit;
    logic [DATA_W-1:0]   emit_byte;

    // Output registers are loaded one cycle ahead, so byte 0 is staged on the accept edge itself.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        last_d      = last_q;
        idx_d       = idx_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        wr_en_d     = 1'b0;
        emit        = 1'b0;
        emit_byte   = '0;
        next_idx    = idx_q + 2'd1;
        end_addr    = {1'b0, addr_q} + {1'b0, remaining_q};

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    addr_d      = cfg_base;
                    remaining_d = cfg_len;
                    err_d       = 2'd0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (remaining_q == '0 || end_addr > (ADDR_W+1)'(DEPTH)) begin
                    err_d   = 2'd1;
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (s_tvalid) begin
                    word_d    = s_tdata;
                    last_d    = s_tlast;
                    idx_d     = 2'd0;
                    emit      = 1'b1;
                    emit_byte = s_tdata[DATA_W-1:0];
                    state_d   = UNPACK;
                end
            end
            UNPACK: begin
                if (idx_q != 2'd3 && remaining_q != '0) begin
                    idx_d     = next_idx;
                    emit      = 1'b1;
                    emit_byte = word_q[{next_idx, 3'b000} +: DATA_W];
                end else if (remaining_q == '0) begin
                    if (!last_q) begin
                        err_d = 2'd3;
                    end
                    state_d = DONE;
                end else if (last_q) begin
                    err_d   = 2'd2;
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit) begin
            wr_en_d     = 1'b1;
            wr_data_d   = emit_byte;
            wr_addr_d   = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
        end

        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
        s_tready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            idx_q       <= 2'd0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            s_tready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            s_tready_q  <= s_tready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && cfg_start) begin
            sum_d = '0;
        end else if (emit) begin
            sum_d = sum_q + 16'(emit_byte);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign s_tready = s_tready_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_nanomamba_weight_loader.sv
// Testbench for nanomamba_weight_loader: a transfer-level model predicts every SRAM write,
// the error code and the checksum; a negedge compare process checks the DUT against it.
module tb_nanomamba_weight_loader;

    localparam int DEPTH = 4736;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [12:0] cfg_base;
    logic [12:0] cfg_len;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [15:0] checksum;

    int          vectors;
    int          miscompares;
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    logic [20:0] exp_q[$];
    logic [20:0] cmp_e;
    logic [1:0]  exp_err;
    logic [15:0] exp_sum;
    int          exp_nwrites;
    logic        prev_wr_en;
    logic        prev_done;

    nanomamba_weight_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_start(cfg_start),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done),
        .err_code (err_code),
        .checksum (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every write must match the next predicted (addr,data); done closes out the transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
                end else begin
                    cmp_e = exp_q.pop_front();
                    checkOutput("wr_addr", 32'(wr_addr), 32'(cmp_e[20:8]));
                    checkOutput("wr_data", 32'(wr_data), 32'(cmp_e[7:0]));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checkOutput("err_code", 32'(err_code), 32'(exp_err));
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
                checkOutput("checksum", 32'(checksum), 32'(exp_sum));
`else
                checkOutput("checksum", 32'(checksum), 32'h0);
`endif
                checkOutput("writes_left", 32'(exp_q.size()), 32'h0);
                checkOutput("done_after_last_write", 32'(prev_wr_en), 32'(exp_nwrites > 0));
                checkOutput("busy_at_done", 32'(busy), 32'h1);
                checkOutput("done_single_pulse", 32'(prev_done), 32'h0);
            end
            prev_wr_en = wr_en;
            prev_done  = done;
        end
    end

    // Builds the expected write list from the transfer rules, then drives config and stream.
    task automatic applyStimulus(input logic [12:0] base, input logic [12:0] len,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3,
                                 input logic [3:0] lasts, input bit gaps, input bit extra_start);
        logic [31:0] w[4];
        logic [12:0] a;
        logic [7:0]  b;
        int          rem;
        int          nwords;
        int          start_cyc;
        int          d0;
        bit          accepted;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        exp_q.delete();
        rem = int'(len);
        a = base;
        nwords = 0;
        exp_sum = 16'h0;
        exp_err = 2'd0;
        if (len == 13'd0 || int'(base) + int'(len) > DEPTH) begin
            exp_err = 2'd1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                nwords++;
                for (int k = 0; k < 4; k++) begin
                    if (rem > 0) begin
                        b = w[i][8*k +: 8];
                        exp_q.push_back({a, b});
                        exp_sum = exp_sum + 16'(b);
                        a = a + 13'd1;
                        rem--;
                    end
                end
                if (rem == 0) begin
                    exp_err = lasts[i] ? 2'd0 : 2'd3;
                    break;
                end
                if (lasts[i]) begin
                    exp_err = 2'd2;
                    break;
                end
            end
        end
        exp_nwrites = exp_q.size();
        d0 = done_cnt;

        @(posedge clk); #1;
        cfg_base  = base;
        cfg_len   = len;
        cfg_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        cfg_start = 1'b0;

        fork
            begin
                for (int i = 0; i < nwords; i++) begin
                    if (gaps) begin
                        repeat ($urandom_range(0, 3)) begin
                            s_tvalid = 1'b0;
                            @(posedge clk); #1;
                        end
                    end
                    s_tvalid = 1'b1;
                    s_tdata  = w[i];
                    s_tlast  = lasts[i];
                    accepted = 1'b0;
                    for (int c = 0; c < 40 && !accepted; c++) begin
                        @(negedge clk);
                        if (s_tready) begin
                            @(posedge clk); #1;
                            accepted = 1'b1;
                        end
                    end
                    checkOutput("word_accepted", 32'(accepted), 32'h1);
                    if (accepted) checkOutput("first_byte_latency", 32'(wr_en), 32'h1);
                    s_tvalid = 1'b0;
                    s_tlast  = 1'b0;
                end
            end
            begin
                if (extra_start) begin
                    repeat (3) @(posedge clk);
                    #1;
                    cfg_base  = 13'h0777;
                    cfg_len   = 13'd3;
                    cfg_start = 1'b1;
                    @(posedge clk); #1;
                    cfg_start = 1'b0;
                end
            end
        join

        for (int c = 0; c < 60 && done_cnt == d0; c++) @(posedge clk);
        checkOutput("done_seen", 32'(done_cnt - d0), 32'h1);
        if (exp_err == 2'd1 && done_cnt != d0)
            checkOutput("range_done_latency", 32'(done_cyc - start_cyc), 32'h2);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("busy_after_done", 32'(busy), 32'h0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
        prev_wr_en = 1'b0; prev_done = 1'b0;
        exp_err = 2'd0; exp_sum = 16'h0; exp_nwrites = 0;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_s_tready", 32'(s_tready), 32'h0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'h0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'h0);
        checkOutput("rst_err_code", 32'(err_code), 32'h0);
        checkOutput("rst_checksum", 32'(checksum), 32'h0);

        applyStimulus(13'h0A50, 13'd8, 32'h04030201, 32'h08070605, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0);
        checkOutput("t1_last_addr", 32'(wr_addr), 32'h0A57);
        checkOutput("t1_last_data", 32'(wr_data), 32'h08);
        checkOutput("t1_err", 32'(err_code), 32'h0);
`ifdef NANOMAMBA_WLOAD_CHECKSUM_EN
        checkOutput("t1_checksum", 32'(checksum), 32'h0024);
`else
        checkOutput("t1_checksum", 32'(checksum), 32'h0);
`endif

        applyStimulus(13'h0000, 13'd6, 32'h44332211, 32'h88776655, 32'h0, 32'h0, 4'b0010, 1'b0, 1'b0);
        checkOutput("t2_last_addr", 32'(wr_addr), 32'h5);
        checkOutput("t2_last_data", 32'(wr_data), 32'h66);

        applyStimulus(13'h1270, 13'h20, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 1'b0);
        checkOutput("t3_err_range", 32'(err_code), 32'h1);
        applyStimulus(13'h0000, 13'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 1'b0);
        applyStimulus(13'h127C, 13'd4, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 1'b0);
        checkOutput("t_edge_last_addr", 32'(wr_addr), 32'h127F);

        applyStimulus(13'h0100, 13'd8, 32'hA1A2A3A4, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 1'b0);
        checkOutput("t4_err_short", 32'(err_code), 32'h2);
        applyStimulus(13'h0200, 13'd4, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
        checkOutput("t4_err_long", 32'(err_code), 32'h3);
        applyStimulus(13'h0010, 13'd9, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h0, 4'b0100, 1'b0, 1'b0);

        applyStimulus(13'h0A50, 13'd8, 32'h04030201, 32'h08070605, 32'h0, 32'h0, 4'b0010, 1'b1, 1'b1);
        checkOutput("t5_last_addr", 32'(wr_addr), 32'h0A57);

        // Reset lands while byte 2 of the first word is on the write port.
        exp_q.delete();
        exp_q.push_back({13'h0300, 8'h00});
        exp_q.push_back({13'h0301, 8'h11});
        exp_q.push_back({13'h0302, 8'h22});
        @(posedge clk); #1;
        cfg_base = 13'h0300; cfg_len = 13'd8; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        s_tvalid = 1'b1; s_tdata = 32'h33221100; s_tlast = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 30 && !hit; c++) begin
                @(negedge clk);
                if (wr_en && wr_addr == 13'h0302) hit = 1'b1;
            end
            checkOutput("rst_test_byte2_seen", 32'(hit), 32'h1);
        end
        s_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_writes_before", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postrst_busy", 32'(busy), 32'h0);
        checkOutput("postrst_s_tready", 32'(s_tready), 32'h0);
        applyStimulus(13'h0300, 13'd4, 32'h33221100, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 1'b0);
        checkOutput("postrst_err", 32'(err_code), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
